// File: rtl/adxl362_spi_responder_pkg.sv
// Shared constants for the ADXL362 SPI responder: command codes, register
// addresses, soft-reset key, FSM states and sample-formatting helpers.
package adxl362_spi_responder_pkg;

    localparam logic [7:0] CMD_WRITE      = 8'h0A;
    localparam logic [7:0] CMD_READ       = 8'h0B;

    localparam logic [7:0] ADDR_DEVID_AD  = 8'h00;
    localparam logic [7:0] ADDR_DEVID_MST = 8'h01;
    localparam logic [7:0] ADDR_PARTID    = 8'h02;
    localparam logic [7:0] ADDR_XDATA_L   = 8'h0E;
    localparam logic [7:0] ADDR_XDATA_H   = 8'h0F;
    localparam logic [7:0] ADDR_YDATA_L   = 8'h10;
    localparam logic [7:0] ADDR_YDATA_H   = 8'h11;
    localparam logic [7:0] ADDR_ZDATA_L   = 8'h12;
    localparam logic [7:0] ADDR_ZDATA_H   = 8'h13;
    localparam logic [7:0] ADDR_SOFT_RST  = 8'h1F;
    localparam logic [7:0] ADDR_POWER_CTL = 8'h2D;

    localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_t;

    // Low byte of a 12-bit sample register pair.
    function automatic logic [7:0] sample_lo(input logic [11:0] s);
        return s[7:0];
    endfunction

    // High byte: sign-extended top nibble.
    function automatic logic [7:0] sample_hi(input logic [11:0] s);
        return {{4{s[11]}}, s[11:8]};
    endfunction

endpackage

// File: rtl/adxl362_spi_responder_shifter.sv
// Bit-level SPI engine: 3-bit down counter, MOSI shift-in on rising edges,
// MISO driven from a parallel byte on falling edges.
module adxl362_spi_responder_shifter
    import adxl362_spi_responder_pkg::*;
(
    input  logic       clk_SPI,
    input  logic       reset,
    input  logic       n_CS,
    input  logic       enable,
    input  logic       MOSI,
    input  logic       out_en,
    input  logic [7:0] out_byte,
    output logic       MISO,
    output logic [7:0] byte_in,
    output logic       byte_done
);

    logic [2:0] bit_cnt;
    logic [6:0] shreg;

    // Completed byte includes the bit being sampled on this edge, so the
    // owner can act on it at the same rising edge.
    assign byte_in   = {shreg, MOSI};
    assign byte_done = enable && (bit_cnt == 3'd0);

    // Shift MOSI in while enabled; counter wraps 0 -> 7 for the next byte.
    always_ff @(posedge clk_SPI) begin
        if (!reset || !enable) begin
            bit_cnt <= 3'd7;
            shreg   <= '0;
        end else begin
            shreg   <= byte_in[6:0];
            bit_cnt <= bit_cnt - 3'd1;
        end
    end

    // Present the current bit half a cycle ahead of the initiator's sample.
    always_ff @(negedge clk_SPI) begin
        if (!reset || n_CS || !out_en)
            MISO <= 1'b0;
        else
            MISO <= out_byte[bit_cnt];
    end

endmodule

// File: rtl/adxl362_spi_responder.sv
// ADXL362 register-file model behind an SPI mode-0 slave: command decode,
// address counter, coherent sample snapshot and read mux.
module adxl362_spi_responder
    import adxl362_spi_responder_pkg::*;
#(
    parameter logic [7:0] DEVID_AD  = 8'hAD,
    parameter logic [7:0] DEVID_MST = 8'h1D,
    parameter logic [7:0] PARTID    = 8'hF2
) (
    input  logic        clk_SPI,
    input  logic        reset,
    input  logic        n_CS,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] x_sample,
    input  logic [11:0] y_sample,
    input  logic [11:0] z_sample,
    output logic [7:0]  power_ctl,
    output logic        measure_on,
    output logic        cmd_error
);

    state_t      state;
    logic        is_read;
    logic        armed;     // low after a reset taken with n_CS low
    logic [7:0]  addr;
    logic [11:0] sx, sy, sz;
    logic        enable;
    logic        byte_done;
    logic [7:0]  byte_in;
    logic [7:0]  rd_byte;

    assign enable     = !n_CS && armed && (state != ST_IGNORE);
    assign measure_on = (power_ctl[1:0] == 2'b10);

    adxl362_spi_responder_shifter u_shifter (
        .clk_SPI   (clk_SPI),
        .reset     (reset),
        .n_CS      (n_CS),
        .enable    (enable),
        .MOSI      (MOSI),
        .out_en    (state == ST_RDATA),
        .out_byte  (rd_byte),
        .MISO      (MISO),
        .byte_in   (byte_in),
        .byte_done (byte_done)
    );

    // Read map over the shadow samples captured at transaction start.
    always_comb begin
        rd_byte = 8'h00;
        case (addr)
            ADDR_DEVID_AD:  rd_byte = DEVID_AD;
            ADDR_DEVID_MST: rd_byte = DEVID_MST;
            ADDR_PARTID:    rd_byte = PARTID;
            ADDR_XDATA_L:   rd_byte = sample_lo(sx);
            ADDR_XDATA_H:   rd_byte = sample_hi(sx);
            ADDR_YDATA_L:   rd_byte = sample_lo(sy);
            ADDR_YDATA_H:   rd_byte = sample_hi(sy);
            ADDR_ZDATA_L:   rd_byte = sample_lo(sz);
            ADDR_ZDATA_H:   rd_byte = sample_hi(sz);
            ADDR_POWER_CTL: rd_byte = power_ctl;
            default:        rd_byte = 8'h00;
        endcase
    end

    // Transaction FSM, address counter and register writes.
    always_ff @(posedge clk_SPI) begin
        if (!reset) begin
            state     <= ST_IDLE;
            armed     <= n_CS;
            is_read   <= 1'b0;
            addr      <= 8'h00;
            power_ctl <= 8'h00;
            cmd_error <= 1'b0;
            sx        <= '0;
            sy        <= '0;
            sz        <= '0;
        end else begin
            cmd_error <= 1'b0;
            if (n_CS) begin
                state <= ST_IDLE;
                armed <= 1'b1;
            end else if (armed) begin
                case (state)
                    ST_IDLE: begin
                        sx    <= x_sample;
                        sy    <= y_sample;
                        sz    <= z_sample;
                        state <= ST_CMD;
                    end
                    ST_CMD: if (byte_done) begin
                        if (byte_in == CMD_WRITE) begin
                            is_read <= 1'b0;
                            state   <= ST_ADDR;
                        end else if (byte_in == CMD_READ) begin
                            is_read <= 1'b1;
                            state   <= ST_ADDR;
                        end else begin
                            cmd_error <= 1'b1;
                            state     <= ST_IGNORE;
                        end
                    end
                    ST_ADDR: if (byte_done) begin
                        addr  <= byte_in;
                        state <= is_read ? ST_RDATA : ST_WDATA;
                    end
                    ST_WDATA: if (byte_done) begin
                        if (addr == ADDR_POWER_CTL)
                            power_ctl <= byte_in;
                        else if (addr == ADDR_SOFT_RST && byte_in == SOFT_RESET_KEY)
                            power_ctl <= 8'h00;
                        addr <= addr + 8'd1;
                    end
                    ST_RDATA: if (byte_done) addr <= addr + 8'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Scoreboard bench: the driver pushes expected read bytes as it issues SPI
// transactions; a monitor collects MISO bytes and compares in order.
module tb_adxl362_spi_responder;

    logic        clk_SPI = 1'b0;
    logic        reset   = 1'b0;
    logic        n_CS    = 1'b1;
    logic        MOSI    = 1'b0;
    logic        MISO;
    logic [11:0] x_sample = '0, y_sample = '0, z_sample = '0;
    logic [7:0]  power_ctl;
    logic        measure_on;
    logic        cmd_error;

    adxl362_spi_responder dut (
        .clk_SPI(clk_SPI), .reset(reset), .n_CS(n_CS), .MOSI(MOSI), .MISO(MISO),
        .x_sample(x_sample), .y_sample(y_sample), .z_sample(z_sample),
        .power_ctl(power_ctl), .measure_on(measure_on), .cmd_error(cmd_error)
    );

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [7:0]  exp_q[$];
    bit          cap = 0;
    logic [7:0]  m_pctl = 8'h00;
    logic [11:0] m_x, m_y, m_z;
    int          m_err = 0;
    int          err_pulses = 0;

    // Monitor: assemble captured MISO bits into bytes and check them
    logic [7:0] mon_sh = '0;
    int         mon_n = 0;
    int         mon_idx = 0;
    always @(posedge clk_SPI) begin
        if (cap && !n_CS) begin
            mon_sh = {mon_sh[6:0], MISO};
            mon_n++;
            if (mon_n == 8) begin
                logic [7:0] e;
                mon_n = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL miso_byte[%0d]: got %02h, no byte expected", mon_idx, mon_sh);
                end else begin
                    e = exp_q.pop_front();
                    if (mon_sh !== e) begin
                        errors++;
                        $display("FAIL miso_byte[%0d]: got %02h expected %02h", mon_idx, mon_sh, e);
                    end
                end
                mon_idx++;
            end
        end
    end

    // Count cycles where cmd_error is high
    always @(negedge clk_SPI) if (cmd_error === 1'b1) err_pulses++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lo(input logic [11:0] s);
        return 8'(s % 256);
    endfunction

    function automatic logic [7:0] hi(input logic [11:0] s);
        int v;
        v = s / 256;
        if (s >= 12'h800) v = v + 8'hF0;
        return 8'(v);
    endfunction

    function automatic logic [7:0] mrd(input logic [7:0] a);
        case (a)
            8'h00: return 8'hAD;
            8'h01: return 8'h1D;
            8'h02: return 8'hF2;
            8'h0E: return lo(m_x);
            8'h0F: return hi(m_x);
            8'h10: return lo(m_y);
            8'h11: return hi(m_y);
            8'h12: return lo(m_z);
            8'h13: return hi(m_z);
            8'h2D: return m_pctl;
            default: return 8'h00;
        endcase
    endfunction

    function automatic void mwr(input logic [7:0] a, input logic [7:0] d);
        if (a == 8'h2D) m_pctl = d;
        else if (a == 8'h1F && d == 8'h52) m_pctl = 8'h00;
    endfunction

    task automatic tick();
        #5 clk_SPI = 1'b1;
        #5 clk_SPI = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit c);
        cap = c;
        for (int i = 7; i >= 0; i--) begin
            MOSI = b[i];
            tick();
        end
    endtask

    task automatic begin_txn();
        m_x = x_sample; m_y = y_sample; m_z = z_sample;
        n_CS = 1'b0;
    endtask

    task automatic end_txn();
        cap = 0;
        n_CS = 1'b1;
        MOSI = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_power_ctl"}, power_ctl, m_pctl);
        check({tag, "_measure_on"}, measure_on, (m_pctl % 4) == 2);
    endtask

    // Read burst of n bytes; optionally change X after byte change_at
    task automatic rd_burst(input logic [7:0] a0, input int n, input int change_at,
                            input logic [11:0] x_new);
        logic [7:0] a;
        a = a0;
        begin_txn();
        send_byte(8'h0B, 0);
        send_byte(a, 0);
        for (int k = 0; k < n; k++) begin
            if (k == change_at) x_sample = x_new;
            exp_q.push_back(mrd(a));
            send_byte(8'($urandom), 1);
            a = a + 8'd1;
        end
        end_txn();
    endtask

    task automatic wr1(input logic [7:0] a, input logic [7:0] d);
        begin_txn();
        send_byte(8'h0A, 0);
        send_byte(a, 0);
        mwr(a, d);
        send_byte(d, 0);
        end_txn();
    endtask

    task automatic bad_cmd(input logic [7:0] c);
        begin_txn();
        send_byte(c, 0);
        check("cmd_error_high", cmd_error, 1'b1);
        m_err++;
        exp_q.push_back(8'h00);
        send_byte(8'h2D, 1);
        check("cmd_error_low", cmd_error, 1'b0);
        exp_q.push_back(8'h00);
        send_byte(8'h0B, 1);
        end_txn();
    endtask

    initial begin
        logic [7:0] interesting[8];
        interesting = '{8'h00, 8'h0E, 8'h10, 8'h12, 8'h2D, 8'hFF, 8'h1F, 8'h0D};

        // Reset with n_CS high
        tick(); tick();
        reset = 1'b1;
        tick();
        check("reset_miso", MISO, 1'b0);
        check("reset_cmd_error", cmd_error, 1'b0);
        check_regs("reset");

        // Write POWER_CTL = 0x02
        wr1(8'h2D, 8'h02);
        check_regs("wr_pctl");
        check("wr_pctl_no_err", err_pulses, 0);

        // X = 0x123 reads
        x_sample = 12'h123;
        rd_burst(8'h0E, 1, -1, '0);
        rd_burst(8'h0F, 1, -1, '0);

        // Negative X, burst through Y/Z, X changes mid-burst
        x_sample = 12'hF85; y_sample = 12'h7A4; z_sample = 12'h801;
        rd_burst(8'h0E, 6, 2, 12'h000);

        // ID registers, unmapped address, wrap from 0xFF
        rd_burst(8'h00, 3, -1, '0);
        rd_burst(8'h40, 1, -1, '0);
        rd_burst(8'hFF, 2, -1, '0);
        rd_burst(8'h2D, 1, -1, '0);

        // Unknown command
        bad_cmd(8'h0C);
        check_regs("bad_cmd");

        // Write aborted after 5 data bits
        begin_txn();
        send_byte(8'h0A, 0);
        send_byte(8'h2D, 0);
        for (int i = 7; i >= 3; i--) begin
            MOSI = i[0];
            tick();
        end
        end_txn();
        check_regs("partial_wr");
        wr1(8'h1F, 8'h52);
        check_regs("soft_reset");

        // Reset mid-transaction: later bits must be ignored until CS cycles
        wr1(8'h2D, 8'h0A);
        begin_txn();
        send_byte(8'h0A, 0);
        send_byte(8'h2D, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        m_pctl = 8'h00;
        send_byte(8'h03, 0);
        exp_q.push_back(8'h00);
        send_byte(8'h00, 1);
        end_txn();
        check_regs("mid_reset");
        rd_burst(8'h2D, 1, -1, '0);

        // Randomised transactions
        for (int t = 0; t < 40; t++) begin
            int kind;
            x_sample = 12'($urandom); y_sample = 12'($urandom); z_sample = 12'($urandom);
            kind = $urandom_range(0, 9);
            if (kind < 5) begin
                logic [7:0] a;
                a = ($urandom_range(0, 1) == 0) ? interesting[$urandom_range(0, 7)] : 8'($urandom);
                rd_burst(a, $urandom_range(1, 4), $urandom_range(0, 4), 12'($urandom));
            end else if (kind < 9) begin
                logic [7:0] a, d;
                int n;
                a = ($urandom_range(0, 2) == 0) ? 8'h1F : 8'h2D;
                n = $urandom_range(1, 2);
                begin_txn();
                send_byte(8'h0A, 0);
                send_byte(a, 0);
                for (int k = 0; k < n; k++) begin
                    d = 8'($urandom);
                    if (a == 8'h1F && $urandom_range(0, 1) == 1) d = 8'h52;
                    mwr(a, d);
                    send_byte(d, 0);
                    a = a + 8'd1;
                end
                end_txn();
                check_regs("rand_wr");
            end else begin
                logic [7:0] c;
                c = 8'($urandom);
                if (c == 8'h0A || c == 8'h0B) c = 8'hFF;
                bad_cmd(c);
            end
        end

        tick(); tick();
        check("scoreboard_drained", exp_q.size(), 0);
        check("cmd_error_pulses", err_pulses, m_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
